// File: rtl/prime_if.sv
// Signal bundle for the prime detector: the nibble inputs, the clear strobe,
// and the combinational, registered and counted results.
interface prime_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               A;
  logic               B;
  logic               C;
  logic               D;
  logic               clr_count;
  logic               F;
  logic               F_q;
  logic [COUNT_W-1:0] hit_count;

  // The side that supplies the nibble and consumes the results.
  modport master (
    output A, B, C, D, clr_count,
    input  F, F_q, hit_count
  );

  // The detector itself.
  modport slave (
    input  A, B, C, D, clr_count,
    output F, F_q, hit_count
  );
endinterface

// File: rtl/prime.sv
// 4-bit prime detector. F is a pure mask lookup on N = {A,B,C,D}. F_q is F
// delayed by one clock, and hit_count counts the clock edges at which F was 1,
// saturating at all-ones.
module prime #(
  parameter logic [15:0] PRIME_MASK = 16'h28AC,
  parameter int unsigned COUNT_W    = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  prime_if.slave   bus
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [3:0] n;

  assign n = {bus.A, bus.B, bus.C, bus.D};

  // The mask index is the single source of truth for F, so a non-default
  // PRIME_MASK retargets the detector without touching the logic.
  assign bus.F = PRIME_MASK[n];

  // Registered copy of F for downstream sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    if (!rst_n) begin
      bus.F_q <= 1'b0;
    end else begin
      bus.F_q <= bus.F;
    end
  end

  // Saturating hit counter with a synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hit_count <= '0;
    end else if (bus.clr_count) begin
      // NOTE: clear is tested first so it wins even when F=1 on the same edge.
      bus.hit_count <= '0;
    end else if (bus.F && (bus.hit_count != COUNT_MAX)) begin
      bus.hit_count <= bus.hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_prime.sv
// Self-checking bench for prime: a default instance, a 3-bit-counter instance
// for saturation, and a custom-mask instance, all driven with the same nibble.
// Expected values go into a scoreboard queue as each step is driven and are
// popped in order when the outputs are sampled.
module tb_prime;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  logic clk;
  logic rst_n;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  prime_if #(.COUNT_W(8)) bus_def ();
  prime_if #(.COUNT_W(3)) bus_sat ();
  prime_if #(.COUNT_W(8)) bus_msk ();

  prime #(.PRIME_MASK(16'h28AC), .COUNT_W(8)) dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_def.slave)
  );

  prime #(.PRIME_MASK(16'h28AC), .COUNT_W(3)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat.slave)
  );

  prime #(.PRIME_MASK(16'h0001), .COUNT_W(8)) dut_msk (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_msk.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Independent reference: trial division.
  function automatic logic is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d < v; d++)
      if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_n(input logic [3:0] v);
    {bus_def.A, bus_def.B, bus_def.C, bus_def.D} = v;
    {bus_sat.A, bus_sat.B, bus_sat.C, bus_sat.D} = v;
    {bus_msk.A, bus_msk.B, bus_msk.C, bus_msk.D} = v;
  endtask

  task automatic set_clr(input logic v);
    bus_def.clr_count = v;
    bus_sat.clr_count = v;
    bus_msk.clr_count = v;
  endtask

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  logic [3:0] sweep [8];
  int         cnt_def;
  int         cnt_sat;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cnt_def = 0;
    cnt_sat = 0;
    sweep   = '{4'h0, 4'h2, 4'h6, 4'h7, 4'hF, 4'hD, 4'hA, 4'hC};
    rst_n   = 1'b0;
    set_clr(1'b0);
    set_n(4'h0);

    // Combinational sweep with reset held low.
    foreach (sweep[i]) begin
      set_n(sweep[i]);
      push("rst_sweep_F", {7'd0, is_prime(int'(sweep[i]))});
      push("rst_sweep_Fq", 8'd0);
      push("rst_sweep_hit", 8'd0);
      push("rst_sweep_sat_hit", 8'd0);
      #2;
      pop_check({7'd0, bus_def.F});
      pop_check({7'd0, bus_def.F_q});
      pop_check(bus_def.hit_count);
      pop_check({5'd0, bus_sat.hit_count});
      #3;
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep, one nibble per clock.
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      set_n(4'(v));
      push("exh_F", {7'd0, is_prime(v)});
      push("exh_msk_F", {7'd0, (v == 0)});
      #1;
      pop_check({7'd0, bus_def.F});
      pop_check({7'd0, bus_msk.F});
      if (is_prime(v)) begin
        cnt_def++;
        if (cnt_sat < 7) cnt_sat++;
      end
      push("exh_Fq", {7'd0, is_prime(v)});
      push("exh_hit", 8'(cnt_def));
      @(posedge clk);
      #1;
      pop_check({7'd0, bus_def.F_q});
      pop_check(bus_def.hit_count);
    end
    push("exh_final_hit", 8'd6);
    pop_check(bus_def.hit_count);

    // Saturation of the 3-bit counter.
    @(negedge clk);
    set_clr(1'b1);
    set_n(4'h0);
    @(posedge clk);
    #1;
    push("sat_clr_def", 8'd0);
    push("sat_clr_sat", 8'd0);
    pop_check(bus_def.hit_count);
    pop_check({5'd0, bus_sat.hit_count});
    @(negedge clk);
    set_clr(1'b0);
    set_n(4'h7);
    for (int k = 1; k <= 10; k++) begin
      push("sat_hit3", 8'((k > 7) ? 7 : k));
      push("sat_hit8", 8'(k));
      @(posedge clk);
      #1;
      pop_check({5'd0, bus_sat.hit_count});
      pop_check(bus_def.hit_count);
    end

    // Clear priority over increment.
    @(negedge clk);
    set_clr(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_clr(1'b0);
    set_n(4'hD);
    repeat (5) @(posedge clk);
    #1;
    push("clr_pre_hit", 8'd5);
    pop_check(bus_def.hit_count);
    @(negedge clk);
    set_clr(1'b1);
    push("clr_prio_hit", 8'd0);
    push("clr_prio_Fq", 8'd1);
    @(posedge clk);
    #1;
    pop_check(bus_def.hit_count);
    pop_check({7'd0, bus_def.F_q});
    @(negedge clk);
    set_clr(1'b0);
    push("clr_after_hit", 8'd1);
    @(posedge clk);
    #1;
    pop_check(bus_def.hit_count);

    // Asynchronous reset between edges.
    @(negedge clk);
    set_clr(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_clr(1'b0);
    set_n(4'h5);
    repeat (4) @(posedge clk);
    #1;
    push("arst_pre_hit", 8'd4);
    push("arst_pre_Fq", 8'd1);
    pop_check(bus_def.hit_count);
    pop_check({7'd0, bus_def.F_q});
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_hit", 8'd0);
    push("arst_Fq", 8'd0);
    push("arst_sat_hit", 8'd0);
    pop_check(bus_def.hit_count);
    pop_check({7'd0, bus_def.F_q});
    pop_check({5'd0, bus_sat.hit_count});
    set_n(4'h2);
    #1;
    push("arst_F_n2", 8'd1);
    pop_check({7'd0, bus_def.F});
    set_n(4'h4);
    #1;
    push("arst_F_n4", 8'd0);
    pop_check({7'd0, bus_def.F});
    @(negedge clk);
    set_n(4'h3);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push("arst_first_hit", 8'd1);
    push("arst_first_Fq", 8'd1);
    pop_check(bus_def.hit_count);
    pop_check({7'd0, bus_def.F_q});

    // Custom mask instance.
    @(negedge clk);
    set_n(4'h0);
    #1;
    push("msk_F_n0", 8'd1);
    push("def_F_n0", 8'd0);
    pop_check({7'd0, bus_msk.F});
    pop_check({7'd0, bus_def.F});
    set_n(4'h2);
    #1;
    push("msk_F_n2", 8'd0);
    push("def_F_n2", 8'd1);
    pop_check({7'd0, bus_msk.F});
    pop_check({7'd0, bus_def.F});

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prime.md
Name: prime

Overview:
- 4-bit prime-number detector. Inputs A (MSB), B, C, D form an unsigned nibble N = {A,B,C,D}, range 0..15.
- Output F is combinational and is 1 when N is prime (2, 3, 5, 7, 11, 13).
- A registered copy of F and a saturating hit counter are provided for downstream sampling and statistics.
- Used as a small leaf block in combinational-logic exercises and as a reference decoder.

Parameters:
- PRIME_MASK, 16'h28AC, lookup mask. Bit k set means N=k is flagged. The default sets bits 2, 3, 5, 7, 11 and 13.
- COUNT_W, 8, width of the hit counter (minimum 1).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- F  output  1  combinational prime flag for the current {A,B,C,D}
- A  input  1  bit 3 (MSB) of N
- B  input  1  bit 2 of N
- C  input  1  bit 1 of N
- D  input  1  bit 0 (LSB) of N
- F_q  output  1  F registered on the rising edge of clk
- hit_count  output  COUNT_W  number of clock edges at which F was 1, saturating
- clr_count  input  1  synchronous clear of hit_count, active high

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- While rst_n=0:
  - F_q=0 and hit_count=0 immediately, independent of clk.
  - F stays purely combinational and remains valid during reset.
- F = PRIME_MASK[N], with no clock dependency and zero latency.
- Default truth table: F=1 for N in {2,3,5,7,11,13}. F=0 for N in {0,1,4,6,8,9,10,12,14,15}.
  - Equivalent sum-of-products: F = A'B'C + A'BD + BC'D + AB'CD.
  - Either the SOP form or the mask index is acceptable, provided they agree for the default mask.
  - For a non-default PRIME_MASK, only the mask index defines F.
- F_q: on each rising clk edge with rst_n=1, F_q <= F. Latency is one cycle.
- hit_count, on each rising clk edge with rst_n=1:
  - If clr_count=1: hit_count <= 0. Clear has priority over increment, even when F=1 in the same cycle.
  - Else if F=1 and hit_count < 2^COUNT_W-1: hit_count <= hit_count+1.
  - Else hold. At all-ones the counter saturates and does not wrap.
- Input changes between clock edges affect F immediately. F_q and hit_count sample only at the edge.
- Reset asserted mid-operation clears F_q and hit_count at once. The first increment after rst_n deasserts occurs at the first rising edge with F=1.
- X or Z on any of A..D: F may go X; no requirement beyond propagation.

Test Plan:
- Combinational sweep with reset held low: apply N=0000, 0010, 0110, 0111, 1111, 1101, 1010, 1100, each for 5 time units -> F = 0, 1, 0, 1, 0, 1, 0, 0. F_q=0 and hit_count=0 throughout.
- Exhaustive N=0..15, one per clock with rst_n=1 and clr_count=0 -> F matches the default truth table. F_q equals the previous cycle's F. hit_count ends at 6.
- Saturation with COUNT_W=3: hold N=7 for 10 clocks -> hit_count goes 1..7, then stays at 7.
- Clear priority: N=13, clr_count=1 for one edge with hit_count=5 -> hit_count=0 at that edge, then 1 on the next edge after clr_count=0.
- Asynchronous reset: with hit_count=4 and F_q=1, drop rst_n between edges -> both go to 0 immediately with no clock. F still tracks the inputs.
- Custom mask: PRIME_MASK=16'h0001, N=0 -> F=1; N=2 -> F=0.
